sa_drain: RTL
=============

Name: sa_drain

Overview:
- Result collector directly downstream of the systolic array.
- Each PE asserts its result valid at its own wavefront time. This block captures all DIMENSION x DIMENSION results into a capture bank.
- Once the tile is complete, it moves the tile into an output bank and streams it out one row per beat over a valid/ready interface, towards the writeback buffer.
- Double banking lets the next tile be collected while the previous one drains.

Parameters:
- DIMENSION, 4, array edge; tile is DIMENSION x DIMENSION.
- WIDTH, 16, result word width (float16 bit pattern, passed through untouched).

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
- DVI  input  [DIMENSION-1:0][DIMENSION-1:0]  per-PE result valid, [row][col].
- DI  input  [DIMENSION-1:0][DIMENSION-1:0][WIDTH-1:0]  per-PE result data, [row][col].
- M_VALID  output  1  output beat valid.
- M_READY  input  1  downstream accepts the beat.
- M_DATA  output  [DIMENSION-1:0][WIDTH-1:0]  one row (or column, see option) of the tile.
- M_ROW  output  [$clog2(DIMENSION)-1:0]  index of the current beat within the tile.
- M_LAST  output  1  high on the final beat of the tile.
- BUSY  output  1  any capture flag set, or output bank holds data.
- OVERFLOW  output  1  sticky error flag.

Behaviour:
- Reset: on RST sampled high, the following take effect at that edge regardless of state:
  - M_VALID=0, M_DATA=0, M_ROW=0, M_LAST=0, OVERFLOW=0, BUSY=0.
  - All capture flags cleared; output bank marked empty.
  - A reset mid-drain or mid-capture discards the tile.
- Capture:
  - When DVI[i][j]=1 and flag[i][j]=0, store DI[i][j] in cap[i][j] and set flag[i][j].
  - When DVI[i][j]=1 and flag[i][j]=1, drop the data, keep the stored value, and set OVERFLOW. OVERFLOW stays set until RST.
- Tile complete: (flag OR DVI-accepted) is all ones at a clock edge.
- Transfer:
  - Occurs at the completing edge when the output bank is empty, or is releasing in that same cycle (final beat handshake, M_VALID & M_READY & M_LAST). The final arriving result is bypassed straight into the output bank.
  - At that edge: cap is copied to out, all flags are cleared, the output bank is marked full, and M_ROW=0.
  - Latency: M_VALID rises the cycle after the edge that sampled the last DVI.
- Transfer blocked (output bank full and not releasing):
  - The capture bank holds with all flags set.
  - Transfer happens at the edge of the final beat handshake, so there is no idle cycle between tiles.
  - Any DVI arriving while blocked is an overflow, per the capture rules.
- Output state machine, states EMPTY and DRAIN:
  - EMPTY -> DRAIN on transfer.
  - In DRAIN, M_VALID=1, M_DATA=out[M_ROW][*], M_LAST=(M_ROW==DIMENSION-1).
  - On a handshake, M_ROW increments. On the last beat, M_ROW wraps to 0; the machine goes to EMPTY, or stays in DRAIN if a transfer occurs in the same cycle.
  - While M_VALID=1 and M_READY=0, M_DATA, M_ROW and M_LAST are held stable.
  - M_VALID never drops without a handshake, except on RST.
- BUSY = OR of all flags, OR (state==DRAIN). Registered; reflects the post-edge state.
- No arithmetic is performed; data is not modified.

Optional Feature:
- Macro: SA_DRAIN_TRANSPOSE_EN.
- Defined: beat k carries column k, M_DATA[i]=out[i][k]. M_ROW is the column index. Capture and transfer timing are unchanged.
- Undefined: beat k carries row k, M_DATA[j]=out[k][j].

Test Plan:
- All 16 DVI high in one cycle with DI[i][j]=16'h0100+4i+j, M_READY=1 -> M_VALID the next cycle, 4 consecutive beats with rows 0..3 (row 0 = 0100,0101,0102,0103), M_LAST on beat 3, BUSY low after the last beat.
- Diagonal wavefront, DVI[i][j] at cycle i+j (cycles 0..6) -> M_VALID first high at cycle 7, data matches, OVERFLOW=0.
- Tile complete with M_READY=0 for 5 cycles, then 1 -> M_DATA/M_ROW held at row 0 for 5 cycles, then 4 beats; no beat lost or duplicated.
- Second tile completes while the first is stalled at beat 2 -> capture bank holds; after the first tile's M_LAST handshake, row 0 of tile 2 is presented the next cycle with no gap; OVERFLOW=0.
- DVI[2][1] pulsed twice before the tile completes (values 0x3C00 then 0x4000) -> OVERFLOW=1 and stays 1; drained row 2 col 1 = 0x3C00.
- RST asserted for one cycle during beat 1 of a drain -> next cycle M_VALID=0, M_ROW=0, BUSY=0, OVERFLOW=0; a fresh tile afterwards drains normally.
- Repeat the first scenario with SA_DRAIN_TRANSPOSE_EN defined -> beat 0 = 0100,0104,0108,010C.

Source files
------------

// File: rtl/sa_drain.sv
// sa_drain -- result collector behind the systolic array.
//
// Every PE reports its result at its own wavefront time. Each result is
// stored in a capture bank. When all DIMENSION x DIMENSION results are in,
// the tile moves to an output bank. The output bank streams one row per
// beat over valid/ready. With two banks, the next tile can be collected
// while the previous one drains. Data words pass through unmodified.
//
// Optional build macro: SA_DRAIN_TRANSPOSE_EN
//   defined   -> beat k carries column k (M_DATA[i] = out[i][k])
//   undefined -> beat k carries row k    (M_DATA[j] = out[k][j])
//
// Ports:
//   CLK       clock
//   RST       synchronous active-high reset
//   DVI       per-PE result valid  [row][col]
//   DI        per-PE result data   [row][col][WIDTH]
//   M_VALID   output beat valid
//   M_READY   downstream accepts the beat
//   M_DATA    one row (or column) of the tile
//   M_ROW     beat index within the tile
//   M_LAST    final beat of the tile
//   BUSY      capture in progress or output bank occupied (registered)
//   OVERFLOW  sticky: a PE delivered twice into an occupied capture slot
module sa_drain #(
    parameter int DIMENSION = 4,
    parameter int WIDTH     = 16
) (
    input  logic                                           CLK,
    input  logic                                           RST,
    input  logic [DIMENSION-1:0][DIMENSION-1:0]            DVI,
    input  logic [DIMENSION-1:0][DIMENSION-1:0][WIDTH-1:0] DI,
    output logic                                           M_VALID,
    input  logic                                           M_READY,
    output logic [DIMENSION-1:0][WIDTH-1:0]                M_DATA,
    output logic [$clog2(DIMENSION)-1:0]                   M_ROW,
    output logic                                           M_LAST,
    output logic                                           BUSY,
    output logic                                           OVERFLOW
);

    localparam int RW = $clog2(DIMENSION);

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                                         state_q, state_d;
    logic [DIMENSION-1:0][DIMENSION-1:0]            flag_q, flag_d;
    logic [DIMENSION-1:0][DIMENSION-1:0][WIDTH-1:0] cap_q, cap_d;
    logic [DIMENSION-1:0][DIMENSION-1:0][WIDTH-1:0] out_q, out_d;
    logic [RW-1:0]                                  row_q, row_d;
    logic                                           ovf_q, ovf_d;
    logic                                           busy_q, busy_d;

    logic [DIMENSION-1:0][DIMENSION-1:0]            accept;
    logic [DIMENSION-1:0][DIMENSION-1:0]            filled;
    logic                                           complete;
    logic                                           last_beat;
    logic                                           handshake;
    logic                                           releasing;
    logic                                           transfer;

    // Capture and transfer decisions.
    always_comb begin
        accept    = DVI & ~flag_q;
        filled    = flag_q | accept;
        complete  = &filled;
        last_beat = (state_q == DRAIN) && (row_q == RW'(DIMENSION - 1));
        handshake = (state_q == DRAIN) && M_READY;
        releasing = handshake && last_beat;
        // The output bank can take a new tile when it is empty, or when its
        // final beat is handshaking in this cycle. The second case avoids an
        // idle beat between back-to-back tiles.
        transfer  = complete && ((state_q == EMPTY) || releasing);

        cap_d = cap_q;
        for (int i = 0; i < DIMENSION; i++) begin
            for (int j = 0; j < DIMENSION; j++) begin
                if (accept[i][j]) begin
                    cap_d[i][j] = DI[i][j];
                end
            end
        end

        // cap_d already contains the last arriving result. Copying cap_d
        // (not cap_q) bypasses that result straight into the output bank.
        out_d  = transfer ? cap_d : out_q;
        flag_d = transfer ? '0 : filled;
        ovf_d  = ovf_q | (|(DVI & flag_q));
    end

    // Output state machine: next state and beat index.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        unique case (state_q)
            EMPTY: begin
                if (transfer) begin
                    state_d = DRAIN;
                    row_d   = '0;
                end
            end
            DRAIN: begin
                if (handshake) begin
                    if (last_beat) begin
                        row_d   = '0;
                        state_d = transfer ? DRAIN : EMPTY;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                row_d   = '0;
            end
        endcase
        busy_d = (|flag_d) || (state_d == DRAIN);
    end

    // Control registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            row_q   <= '0;
            flag_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    // Data banks. These are not reset because their contents are only
    // observed behind valid flags or state.
    always_ff @(posedge CLK) begin
        cap_q <= cap_d;
        out_q <= out_d;
    end

    // Beat presentation. M_DATA is forced to zero outside DRAIN, so it reads
    // as zero after reset.
    always_comb begin
        M_VALID = (state_q == DRAIN);
        M_ROW   = row_q;
        M_LAST  = last_beat;
        M_DATA  = '0;
        if (state_q == DRAIN) begin
            for (int k = 0; k < DIMENSION; k++) begin
`ifdef SA_DRAIN_TRANSPOSE_EN
                M_DATA[k] = out_q[k][row_q];
`else
                M_DATA[k] = out_q[row_q][k];
`endif
            end
        end
    end

    assign BUSY     = busy_q;
    assign OVERFLOW = ovf_q;

endmodule
